cpu8_prog_sequencer: RTL and testbench
======================================

Name: cpu8_prog_sequencer

Overview:
Instruction-stream source for the 8-bit accumulator core. It buffers a short program loaded byte-by-byte over a valid/ready port, then replays it one instruction byte per cycle onto the core's instruction input (opcode in [3:0], operand in [7:4]). After a fixed drain delay it captures the core's accumulator output as the program result. Sits between the tile's I/O pins and the accumulator core.

Parameters:
DEPTH, 16, program buffer entries (power of 2, 2..16)
DRAIN, 3, cycles of NOP issued after the last instruction before result_in is sampled (must be >=1)
NOP_BYTE, 8'h00, byte driven on instr_out when not issuing (opcode 0 = no operation in core)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
load_valid  input  1  program byte offered
load_ready  output  1  sequencer accepts byte this cycle
load_data  input  8  program byte
clear  input  1  pulse: empty program buffer (IDLE only)
start  input  1  pulse: begin playback (IDLE only)
instr_out  output  8  instruction byte to core in8bit
instr_valid  output  1  instr_out carries a program entry (not NOP)
result_in  input  8  core out8bit
result_out  output  8  captured result
done  output  1  one-cycle pulse when result_out updates
busy  output  1  high in RUN or DRAIN
prog_len  output  5  number of stored entries (0..DEPTH)

Behaviour:
- Reset: state IDLE, prog_len=0, instr_out=NOP_BYTE, instr_valid=0, result_out=0, done=0, busy=0, load_ready=1. Buffer contents undefined (not reset).
- All outputs registered.
- States: IDLE, RUN, DRAIN.
- IDLE: load_ready = (prog_len<DEPTH). Byte written at mem[prog_len] on load_valid&&load_ready; prog_len+1. clear has priority over load in the same cycle (prog_len->0, byte dropped). start with clear or load same cycle: clear/load applied, start ignored.
- start in IDLE, prog_len>0: -> RUN, index=0. start with prog_len=0: -> DRAIN directly.
- RUN: one entry per cycle; first entry on instr_out the cycle after start sampled; instr_valid=1 each issue cycle. After entry prog_len-1 issued -> DRAIN. No stall/backpressure.
- DRAIN: instr_out=NOP_BYTE, instr_valid=0 for DRAIN cycles; at the end result_out<=result_in, done=1 for one cycle, -> IDLE. Program retained; start again replays it.
- load_ready=0 and start/clear/load ignored while busy.
- Core latency basis: issued byte latched by core on next edge, regA updated edge after, out8bit edge after that; DRAIN=3 aligns with that.
- prog_len wraps never; saturates at DEPTH with load_ready=0.
- Async reset mid-RUN/DRAIN: immediate return to reset values, no done pulse.

Optional Feature:
CPU8SEQ_LOOP_EN: adds input loop (1b, sampled with start) and stop (1b pulse). Defined: if loop=1 at start, after last entry index wraps to 0 and RUN continues without NOPs; stop during RUN ends the current pass (finish through last entry) then DRAIN. done/result_out only at final DRAIN. Not defined: ports absent, single pass only.

Test Plan:
- Reset, load 8'h31, 8'h51, 8'h22 (ADD3, ADD5, SUB2), start -> instr_out 31,51,22 on 3 consecutive cycles with instr_valid=1, then 3 NOP cycles, done pulse, result_out=8'h06 with the real core attached.
- Load 16 bytes -> prog_len=16, load_ready=0; 17th byte not stored; start issues exactly 16 entries.
- start with prog_len=0 -> no instr_valid, done after DRAIN cycles, result_out=result_in (0 from reset core).
- Load during RUN and start during DRAIN -> ignored; prog_len unchanged, no second playback; clear+load_valid same cycle -> prog_len=0.
- Assert rst_n low mid-RUN at entry 2 -> instr_out=00, busy=0, prog_len=0, done never pulses.
- (LOOP_EN) program 8'h11 (ADD1), loop=1, stop after 5 issues -> 5 ADD1 total (single-entry pass completes), result_out=8'h05.

Source files
------------

// File: rtl/cpu8_prog_sequencer.sv
// Program buffer and replay sequencer feeding the 8-bit accumulator core; captures the core result after a drain delay.
// Optional CPU8SEQ_LOOP_EN adds loop_i/stop_i for repeated playback passes.
module cpu8_prog_sequencer #(
  parameter int          DEPTH    = 16,
  parameter int          DRAIN    = 3,
  parameter logic [7:0]  NOP_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid_i,
  output logic       load_ready_o,
  input  logic [7:0] load_data_i,
  input  logic       clear_i,
  input  logic       start_i,
`ifdef CPU8SEQ_LOOP_EN
  input  logic       loop_i,
  input  logic       stop_i,
`endif
  output logic [7:0] instr_out_o,
  output logic       instr_valid_o,
  input  logic [7:0] result_in_i,
  output logic [7:0] result_out_o,
  output logic       done_o,
  output logic       busy_o,
  output logic [4:0] prog_len_o
);

  localparam int         AW     = $clog2(DEPTH);
  localparam int         CW     = $clog2(DRAIN + 1);
  localparam logic [4:0] DEPTH5 = 5'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  logic [7:0]    mem [DEPTH];
  state_e        state_q;
  logic [4:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    prog_len_q, prog_len_d;
  logic [7:0]    instr_out_q;
  logic          instr_valid_q;
  logic [7:0]    result_q;
  logic          done_q;
  logic          busy_q;
  logic          load_ready_q;
  logic          in_idle, load_fire, start_fire, wrap;

  assign in_idle    = (state_q == S_IDLE);
  assign load_fire  = in_idle && load_valid_i && load_ready_q && !clear_i;
  // Clear or an accepted load in the same cycle takes precedence over start.
  assign start_fire = in_idle && start_i && !clear_i && !load_fire;

`ifdef CPU8SEQ_LOOP_EN
  logic loop_q, stop_q;
  assign wrap = loop_q && !(stop_q || stop_i);
`else
  assign wrap = 1'b0;
`endif

  always_comb begin
    prog_len_d = prog_len_q;
    if (in_idle) begin
      if (clear_i)
        prog_len_d = 5'd0;
      else if (load_fire)
        prog_len_d = prog_len_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire)
      mem[prog_len_q[AW-1:0]] <= load_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= 5'd0;
      cnt_q         <= '0;
      prog_len_q    <= 5'd0;
      instr_out_q   <= NOP_BYTE;
      instr_valid_q <= 1'b0;
      result_q      <= 8'h00;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      load_ready_q  <= 1'b1;
`ifdef CPU8SEQ_LOOP_EN
      loop_q        <= 1'b0;
      stop_q        <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          prog_len_q   <= prog_len_d;
          load_ready_q <= (prog_len_d < DEPTH5);
          if (start_fire) begin
            busy_q       <= 1'b1;
            load_ready_q <= 1'b0;
`ifdef CPU8SEQ_LOOP_EN
            loop_q       <= loop_i;
            stop_q       <= 1'b0;
`endif
            if (prog_len_q != 5'd0) begin
              state_q       <= S_RUN;
              instr_out_q   <= mem[0];
              instr_valid_q <= 1'b1;
              idx_q         <= 5'd1;
            end else begin
              state_q <= S_DRAIN;
              cnt_q   <= CW'(1);
            end
          end
        end
        S_RUN: begin
`ifdef CPU8SEQ_LOOP_EN
          stop_q <= stop_q | stop_i;
`endif
          // idx_q == prog_len_q means the last entry is already on instr_out.
          if (idx_q == prog_len_q) begin
            if (wrap) begin
              instr_out_q <= mem[0];
              idx_q       <= 5'd1;
            end else begin
              instr_out_q   <= NOP_BYTE;
              instr_valid_q <= 1'b0;
              state_q       <= S_DRAIN;
              cnt_q         <= CW'(1);
            end
          end else begin
            instr_out_q <= mem[idx_q[AW-1:0]];
            idx_q       <= idx_q + 5'd1;
          end
        end
        S_DRAIN: begin
          if (cnt_q == CW'(DRAIN)) begin
            result_q     <= result_in_i;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
            load_ready_q <= (prog_len_q < DEPTH5);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign load_ready_o  = load_ready_q;
  assign instr_out_o   = instr_out_q;
  assign instr_valid_o = instr_valid_q;
  assign result_out_o  = result_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;
  assign prog_len_o    = prog_len_q;

endmodule

// File: tb/tb_cpu8_prog_sequencer.sv
// Randomized scoreboard bench for cpu8_prog_sequencer with a stand-in accumulator core on result_in.
module tb_cpu8_prog_sequencer;
  localparam int DEPTH = 16;
  localparam int DRAIN = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       load_ready_o, instr_valid_o, done_o, busy_o;
  logic [7:0] instr_out_o, result_out_o, result_in;
  logic [4:0] prog_len_o;
`ifdef CPU8SEQ_LOOP_EN
  logic       loop_s = 1'b0;
  logic       stop_s = 1'b0;
`endif

  cpu8_prog_sequencer #(.DEPTH(DEPTH), .DRAIN(DRAIN), .NOP_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid_i(load_valid), .load_ready_o(load_ready_o), .load_data_i(load_data),
    .clear_i(clear), .start_i(start),
`ifdef CPU8SEQ_LOOP_EN
    .loop_i(loop_s), .stop_i(stop_s),
`endif
    .instr_out_o(instr_out_o), .instr_valid_o(instr_valid_o),
    .result_in_i(result_in), .result_out_o(result_out_o),
    .done_o(done_o), .busy_o(busy_o), .prog_len_o(prog_len_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in core: latch instruction, update accumulator, then present it (opcode 1 = ADD, 2 = SUB).
  logic [7:0] core_ir, core_acc, core_out;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ir <= 8'h00; core_acc <= 8'h00; core_out <= 8'h00;
    end else begin
      core_ir <= instr_out_o;
      if (core_ir[3:0] == 4'd1)      core_acc <= core_acc + {4'h0, core_ir[7:4]};
      else if (core_ir[3:0] == 4'd2) core_acc <= core_acc - {4'h0, core_ir[7:4]};
      core_out <= core_acc;
    end
  end
  assign result_in = core_out;

  typedef struct { logic [7:0] v; int at; } exp_t;
  exp_t       exp_instr[$];
  exp_t       exp_res[$];
  logic [7:0] prog[$];
  logic [7:0] acc_model = 8'h00;
  int         errors = 0;
  int         checks = 0;
  int         last_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every issued byte and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (instr_valid_o) begin
        if (exp_instr.size() == 0) begin
          checks++; errors++;
          $display("FAIL instr_unexpected: got %h at cycle %0d want no issue", instr_out_o, cyc);
        end else begin
          e = exp_instr.pop_front();
          chk("instr_out", {24'h0, instr_out_o}, {24'h0, e.v});
          chk("instr_cycle", cyc, e.at);
        end
      end else begin
        chk("nop_byte", {24'h0, instr_out_o}, 32'h0);
      end
      if (done_o) begin
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got result %h at cycle %0d want no done", result_out_o, cyc);
        end else begin
          e = exp_res.pop_front();
          chk("result_out", {24'h0, result_out_o}, {24'h0, e.v});
          chk("done_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic load_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_data  = b;
    chk("load_ready", {31'h0, load_ready_o}, {31'h0, prog.size() < DEPTH});
    @(negedge clk);
    load_valid = 1'b0;
    if (prog.size() < DEPTH) prog.push_back(b);
    chk("prog_len", {27'h0, prog_len_o}, prog.size());
  endtask

  task automatic clear_prog();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    prog.delete();
    chk("prog_len_clear", {27'h0, prog_len_o}, 32'h0);
  endtask

  // Expected issue cycles: entry k in cycle s+k, done in cycle s+len+DRAIN.
  task automatic play();
    int s;
    exp_t e;
    s = cyc + 1;
    last_start = s;
    foreach (prog[k]) begin
      e.v = prog[k]; e.at = s + k;
      exp_instr.push_back(e);
      if (prog[k][3:0] == 4'd1)      acc_model = acc_model + {4'h0, prog[k][7:4]};
      else if (prog[k][3:0] == 4'd2) acc_model = acc_model - {4'h0, prog[k][7:4]};
    end
    e.v = acc_model; e.at = s + prog.size() + DRAIN;
    exp_res.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", {31'h0, busy_o}, 32'h1);
    chk("load_ready_busy", {31'h0, load_ready_o}, 32'h0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_res.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_res.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done after %0d cycles want done", n);
      exp_res.delete();
      exp_instr.delete();
    end
    chk("busy_idle", {31'h0, busy_o}, 32'h0);
  endtask

  function automatic logic [7:0] rand_instr();
    logic [3:0] op;
    logic [3:0] arg;
    op  = 4'($urandom_range(0, 3));
    arg = 4'($urandom_range(0, 15));
    return {arg, op};
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_instr_out", {24'h0, instr_out_o}, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid_o}, 32'h0);
    chk("rst_result", {24'h0, result_out_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_load_ready", {31'h0, load_ready_o}, 32'h1);
    chk("rst_prog_len", {27'h0, prog_len_o}, 32'h0);

    // ADD3, ADD5, SUB2 -> 6
    load_byte(8'h31); load_byte(8'h51); load_byte(8'h22);
    play();
    wait_done();

    // Fill to capacity, offer one extra byte, replay all 16
    clear_prog();
    for (int i = 0; i < DEPTH; i++) load_byte(rand_instr());
    chk("full_ready", {31'h0, load_ready_o}, 32'h0);
    load_byte(8'hFF);
    play();
    wait_done();

    // Empty program: straight to drain
    clear_prog();
    play();
    wait_done();

    // Load/clear/start while busy, start during drain: all ignored
    load_byte(rand_instr()); load_byte(rand_instr()); load_byte(rand_instr());
    play();
    load_valid = 1'b1; load_data = 8'hAA; clear = 1'b1; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load_valid = 1'b0; clear = 1'b0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    chk("prog_len_kept", {27'h0, prog_len_o}, 32'd3);

    // clear beats load; load beats start
    load_valid = 1'b1; load_data = 8'h55; clear = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; clear = 1'b0;
    prog.delete();
    chk("clear_over_load", {27'h0, prog_len_o}, 32'h0);
    load_valid = 1'b1; load_data = 8'h11; start = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; start = 1'b0;
    prog.push_back(8'h11);
    chk("load_over_start", {27'h0, prog_len_o}, 32'd1);
    repeat (6) @(negedge clk);
    chk("no_playback", {31'h0, busy_o}, 32'h0);

    // Random programs with gapped loading, each followed by a replay
    for (int t = 0; t < 6; t++) begin
      int len;
      clear_prog();
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        load_byte(rand_instr());
      end
      play();
      wait_done();
      play();
      wait_done();
    end

    // Asynchronous reset in the middle of playback
    clear_prog();
    for (int i = 0; i < 4; i++) load_byte(rand_instr());
    play();
    for (int n = 0; n < 20 && cyc < last_start + 2; n++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_instr.delete();
    exp_res.delete();
    prog.delete();
    acc_model = 8'h00;
    #1;
    chk("mrst_instr_out", {24'h0, instr_out_o}, 32'h0);
    chk("mrst_instr_valid", {31'h0, instr_valid_o}, 32'h0);
    chk("mrst_busy", {31'h0, busy_o}, 32'h0);
    chk("mrst_prog_len", {27'h0, prog_len_o}, 32'h0);
    chk("mrst_done", {31'h0, done_o}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    load_byte(8'h31); load_byte(8'h22);
    play();
    wait_done();

    chk("queues_empty", exp_instr.size() + exp_res.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
